// File: rtl/mil_word_receiver_pkg.sv
// Shared MIL-STD-1553 receive definitions: line levels, word types and
// frame lengths in half-bit units.
package milStd1553;

  typedef enum logic [1:0] {
    LVL_IDLE = 2'b00,
    LVL_HI   = 2'b01,
    LVL_LO   = 2'b10
  } level_e;

  typedef enum logic {
    WT_DATA = 1'b0,
    WT_CMD  = 1'b1
  } word_type_e;

  localparam int SYNC_HALF_BITS = 3;
  localparam int BIT_HALF_BITS  = 2;
  localparam int WORD_BITS      = 17;

  function automatic level_e decode_level(input logic p, input logic n);
    if (p && !n) return LVL_HI;
    if (!p && n) return LVL_LO;
    return LVL_IDLE;
  endfunction

endpackage

// File: rtl/mil_rx_line_sync.sv
// Two-flop synchronizer for the bipolar bus pair, HI/LO/IDLE decode and a
// one-cycle strobe whenever the decoded level changes.
module mil_rx_line_sync
  import milStd1553::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_mil_p,
  input  logic   i_mil_n,
  output level_e o_lvl,
  output logic   o_edge
);

  logic [1:0] r_meta;
  logic [1:0] r_sync;
  level_e     r_lvl_prev;
  level_e     w_lvl;

  assign w_lvl  = decode_level(r_sync[1], r_sync[0]);
  assign o_lvl  = w_lvl;
  assign o_edge = (w_lvl != r_lvl_prev);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta     <= '0;
      r_sync     <= '0;
      r_lvl_prev <= LVL_IDLE;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the old value,
      // which is what makes this a real two-stage shift chain.
      r_meta     <= {i_mil_p, i_mil_n};
      r_sync     <= r_meta;
      r_lvl_prev <= w_lvl;
    end
  end

endmodule

// File: rtl/mil_word_receiver.sv
// MIL-STD-1553 Manchester word receiver. Define MIL_RX_ERR_COUNT_EN to add
// the saturating err_count output.
module mil_word_receiver
  import milStd1553::*;
#(
  parameter int HALF_BIT_CLKS = 50,
  parameter int TOL_CLKS      = HALF_BIT_CLKS / 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mil_p,
  input  logic        mil_n,
  output logic        out_valid,
  output logic [15:0] out_word,
  output logic        out_cmd,
  output logic        out_err,
  output logic        busy
`ifdef MIL_RX_ERR_COUNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam int H  = HALF_BIT_CLKS;
  localparam int CW = $clog2(8 * H);
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t C_S1       = cnt_t'(H / 2);
  localparam cnt_t C_S2       = cnt_t'(3 * H / 2);
  localparam cnt_t C_SYNC_END = cnt_t'(SYNC_HALF_BITS * H - 1);
  localparam cnt_t C_SYNC_MIN = cnt_t'(SYNC_HALF_BITS * H - TOL_CLKS);
  localparam cnt_t C_SYNC_MAX = cnt_t'(SYNC_HALF_BITS * H + TOL_CLKS);
  localparam cnt_t C_BIT_END  = cnt_t'(BIT_HALF_BITS * H - 1);
  localparam cnt_t C_RES_MIN  = cnt_t'(H - TOL_CLKS);
  localparam cnt_t C_RES_MAX  = cnt_t'(H + TOL_CLKS);
  localparam cnt_t C_RES_LOAD = cnt_t'(H + 1);
  // Gap timing is counted on from the parity bit's phase, so word end is 2H.
  localparam cnt_t C_GAP_SMP  = cnt_t'(BIT_HALF_BITS * H + 3 * H / 2);
  localparam cnt_t C_GAP_MIN  = cnt_t'(BIT_HALF_BITS * H + SYNC_HALF_BITS * H - TOL_CLKS);
  localparam cnt_t C_GAP_MAX  = cnt_t'(BIT_HALF_BITS * H + SYNC_HALF_BITS * H + TOL_CLKS);
  localparam logic [4:0] C_LAST_BIT = 5'(WORD_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC1, S_SYNC2, S_DATA, S_OUT, S_GAP} state_e;

  level_e w_lvl;
  logic   w_edge;

  mil_rx_line_sync u_line_sync (
    .clk     (clk),
    .rst     (rst),
    .i_mil_p (mil_p),
    .i_mil_n (mil_n),
    .o_lvl   (w_lvl),
    .o_edge  (w_edge)
  );

  state_e     r_state, w_state_nxt;
  cnt_t       r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [4:0] r_bit, w_bit_nxt;
  logic [15:0] r_data, w_data_nxt;
  level_e     r_pol, w_pol_nxt, r_s1, w_s1_nxt;
  word_type_e r_type, w_type_nxt, r_out_type;
  logic       r_merr, w_merr_nxt;
  logic       w_load, w_word_err, w_bit_ok, w_bit_val, w_opp;
  logic       r_out_valid, r_out_err;
  logic [15:0] r_out_word;

  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_opp     = (w_lvl != LVL_IDLE) && (w_lvl != r_pol);
  assign w_bit_ok  = (r_s1 != LVL_IDLE) && (w_lvl != LVL_IDLE) && (r_s1 != w_lvl);
  assign w_bit_val = (r_s1 == LVL_HI);
  // Odd parity over 16 data bits plus the parity bit itself.
  assign w_word_err = r_merr | ~w_bit_ok | ~(^{r_data, w_bit_val});

  always_comb begin
    // NOTE: every target gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_inc;
    w_bit_nxt   = r_bit;
    w_data_nxt  = r_data;
    w_pol_nxt   = r_pol;
    w_s1_nxt    = r_s1;
    w_type_nxt  = r_type;
    w_merr_nxt  = r_merr;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_edge && w_lvl != LVL_IDLE) begin
          w_state_nxt = S_SYNC1;
          w_cnt_nxt   = cnt_t'(1);
          w_pol_nxt   = w_lvl;
        end
      end
      S_SYNC1: begin
        if (w_edge) begin
          if (w_opp && r_cnt >= C_SYNC_MIN && r_cnt <= C_SYNC_MAX) begin
            w_state_nxt = S_SYNC2;
            w_cnt_nxt   = cnt_t'(1);
            w_type_nxt  = (r_pol == LVL_HI) ? WT_CMD : WT_DATA;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (r_cnt >= C_SYNC_MAX) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SYNC2: begin
        if (r_cnt == C_S2 && !w_opp) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == C_SYNC_END) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_merr_nxt  = 1'b0;
        end
      end
      S_DATA: begin
        if (r_cnt == C_S1) begin
          w_s1_nxt = w_lvl;
        end else if (r_cnt == C_S2) begin
          w_merr_nxt = r_merr | ~w_bit_ok;
          if (r_bit == C_LAST_BIT) begin
            w_state_nxt = S_OUT;
            w_load      = 1'b1;
          end else begin
            w_data_nxt = {r_data[14:0], w_bit_val};
          end
        end else if (r_cnt == C_BIT_END) begin
          w_cnt_nxt = '0;
          w_bit_nxt = r_bit + 5'd1;
        end else if (w_edge && r_cnt >= C_RES_MIN && r_cnt <= C_RES_MAX) begin
          w_cnt_nxt = C_RES_LOAD;
        end
      end
      S_OUT: w_state_nxt = S_GAP;
      S_GAP: begin
        if (r_cnt == C_GAP_SMP) begin
          if (w_lvl == LVL_IDLE) w_state_nxt = S_IDLE;
          else                   w_pol_nxt   = w_lvl;
        end else if (w_edge && r_cnt >= C_GAP_MIN && r_cnt <= C_GAP_MAX) begin
          if (w_opp) begin
            w_state_nxt = S_SYNC2;
            w_cnt_nxt   = cnt_t'(1);
            w_type_nxt  = (r_pol == LVL_HI) ? WT_CMD : WT_DATA;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (r_cnt > C_GAP_MAX) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_data      <= '0;
      r_pol       <= LVL_IDLE;
      r_s1        <= LVL_IDLE;
      r_type      <= WT_DATA;
      r_merr      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
      r_out_type  <= WT_DATA;
      r_out_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit       <= w_bit_nxt;
      r_data      <= w_data_nxt;
      r_pol       <= w_pol_nxt;
      r_s1        <= w_s1_nxt;
      r_type      <= w_type_nxt;
      r_merr      <= w_merr_nxt;
      r_out_valid <= w_load;
      if (w_load) begin
        r_out_word <= r_data;
        r_out_type <= r_type;
        r_out_err  <= w_word_err;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_word  = r_out_word;
  assign out_cmd   = (r_out_type == WT_CMD);
  assign out_err   = r_out_err;
  assign busy      = (r_state == S_SYNC2) || (r_state == S_DATA) || (r_state == S_OUT);

`ifdef MIL_RX_ERR_COUNT_EN
  logic [15:0] r_err_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (r_out_valid && r_out_err && r_err_count != 16'hFFFF) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_mil_word_receiver.sv
// Directed bench for mil_word_receiver: encodes words onto the bus pair and
// checks strobes, types, error flags and latency against hand-derived values.
module tb_mil_word_receiver;

  localparam int H   = 50;
  localparam int TOL = H / 4;
  localparam int J   = TOL - 1;
  localparam logic [1:0] HI = 2'b10;
  localparam logic [1:0] LO = 2'b01;
  localparam logic [1:0] ID = 2'b00;

  logic        clk = 1'b0;
  logic        rst;
  logic        mil_p, mil_n;
  logic        out_valid, out_cmd, out_err, busy;
  logic [15:0] out_word;
`ifdef MIL_RX_ERR_COUNT_EN
  logic [15:0] err_count;
`endif

  mil_word_receiver #(.HALF_BIT_CLKS(H), .TOL_CLKS(TOL)) dut (
    .clk       (clk),
    .rst       (rst),
    .mil_p     (mil_p),
    .mil_n     (mil_n),
    .out_valid (out_valid),
    .out_word  (out_word),
    .out_cmd   (out_cmd),
    .out_err   (out_err),
    .busy      (busy)
`ifdef MIL_RX_ERR_COUNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          t;
    logic [15:0] w;
    logic        c;
    logic        e;
    logic        b;
  } strobe_t;
  strobe_t q[$];

  always @(negedge clk) begin
    strobe_t s;
    if (out_valid) begin
      s.t = cyc; s.w = out_word; s.c = out_cmd; s.e = out_err; s.b = busy;
      q.push_back(s);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  int mid_cyc;

  task automatic idle(input int n);
    {mil_p, mil_n} = ID;
    repeat (n) @(negedge clk);
  endtask

  // Drives sync + 17 bits; bad_bit is a wire index driven HI for both halves,
  // rst_half is the half-bit index at which a reset pulse is applied.
  task automatic send_word(input logic [15:0] w, input bit cmd, input bit flip_par,
                           input int bad_bit, input bit jit, input int rst_half);
    logic [1:0] lv[36];
    int         off[37];
    int         dur;
    logic       par, b;
    par = (~^w) ^ flip_par;
    lv[0] = cmd ? HI : LO;
    lv[1] = cmd ? LO : HI;
    for (int i = 0; i < 17; i++) begin
      b = (i < 16) ? w[15-i] : par;
      lv[2+2*i] = b ? HI : LO;
      lv[3+2*i] = b ? LO : HI;
      if (i == bad_bit) begin
        lv[2+2*i] = HI;
        lv[3+2*i] = HI;
      end
    end
    for (int k = 0; k < 37; k++)
      off[k] = (jit && k >= 2 && k < 36) ? ((k % 2 == 1) ? J : -J) : 0;
    for (int k = 0; k < 36; k++) begin
      dur = ((k < 2) ? 3 * H : H) + off[k+1] - off[k];
      {mil_p, mil_n} = lv[k];
      if (k == 1) mid_cyc = cyc;
      if (k == rst_half) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.valid", out_valid, 0);
        check("rst.word", out_word, 16'h0000);
        check("rst.cmd", out_cmd, 0);
        check("rst.busy", busy, 0);
        rst = 1'b0;
        repeat (dur - 2) @(negedge clk);
      end else begin
        repeat (dur) @(negedge clk);
      end
    end
  endtask

  task automatic expect_one(input string tag, input logic [15:0] w, input logic c,
                            input logic e, input logic [15:0] mask);
    check({tag, ".count"}, q.size(), 1);
    if (q.size() > 0) begin
      check({tag, ".word"}, q[0].w & mask, w & mask);
      check({tag, ".cmd"}, q[0].c, c);
      check({tag, ".err"}, q[0].e, e);
      check({tag, ".busy"}, q[0].b, 1);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    {mil_p, mil_n} = ID;
    repeat (3) @(negedge clk);
    check("reset.valid", out_valid, 0);
    check("reset.word", out_word, 16'h0000);
    check("reset.cmd", out_cmd, 0);
    check("reset.err", out_err, 0);
    check("reset.busy", busy, 0);
`ifdef MIL_RX_ERR_COUNT_EN
    check("reset.err_count", err_count, 0);
`endif
    rst = 1'b0;
    idle(5);

    // Command 0001, parity 0; strobe 3 + 36.5H cycles after the mid-sync drive.
    q.delete();
    send_word(16'h0001, 1, 0, -1, 0, -1);
    idle(8 * H);
    expect_one("t1", 16'h0001, 1, 0, 16'hFFFF);
    if (q.size() > 0) check("t1.latency", q[0].t - mid_cyc, 3 + 36 * H + H / 2);
    check("t1.busy_after", busy, 0);

    q.delete();
    send_word(16'hFFA1, 0, 0, -1, 0, -1);
    idle(8 * H);
    expect_one("t2", 16'hFFA1, 0, 0, 16'hFFFF);

    q.delete();
    send_word(16'hFFA1, 0, 0, -1, 1, -1);
    idle(8 * H);
    expect_one("t2j", 16'hFFA1, 0, 0, 16'hFFFF);

`ifdef MIL_RX_ERR_COUNT_EN
    check("t3.err_count_before", err_count, 0);
`endif
    q.delete();
    send_word(16'hAB45, 0, 1, -1, 0, -1);
    idle(8 * H);
    expect_one("t3", 16'hAB45, 0, 1, 16'hFFFF);
`ifdef MIL_RX_ERR_COUNT_EN
    check("t3.err_count_after", err_count, 1);
`endif

    // Word bit 5 is wire bit 10 (MSB first).
    q.delete();
    send_word(16'h0002, 0, 0, 10, 0, -1);
    idle(8 * H);
    expect_one("t4", 16'h0002, 0, 1, 16'hFFDF);

    q.delete();
    send_word(16'h0001, 1, 0, -1, 0, -1);
    send_word(16'h0002, 0, 0, -1, 0, -1);
    idle(8 * H);
    check("t5.count", q.size(), 2);
    if (q.size() > 1) begin
      check("t5.spacing", q[1].t - q[0].t, 40 * H);
      check("t5.w0", q[0].w, 16'h0001);
      check("t5.c0", q[0].c, 1);
      check("t5.e0", q[0].e, 0);
      check("t5.w1", q[1].w, 16'h0002);
      check("t5.c1", q[1].c, 0);
      check("t5.e1", q[1].e, 0);
    end

    q.delete();
    {mil_p, mil_n} = HI;
    repeat (2 * H) @(negedge clk);
    {mil_p, mil_n} = LO;
    repeat (3 * H) @(negedge clk);
    idle(8 * H);
    check("t6.runt_count", q.size(), 0);
    send_word(16'h0001, 1, 0, -1, 0, -1);
    idle(8 * H);
    expect_one("t6", 16'h0001, 1, 0, 16'hFFFF);

    // Reset at the first half of wire bit 8 (half index 2 + 2*8).
    q.delete();
    send_word(16'h1234, 0, 0, -1, 0, 18);
    idle(8 * H);
    check("t6.rst_count", q.size(), 0);
    check("t6.rst_word", out_word, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
